uart_bus_master: RTL
====================

// Module: uart_bus_master
// PURPOSE
//  Bus initiator driving the UART peripheral's host interface (cs/as/rw/addr/wr_data -> rd_data/rdy).
//  Converts single-byte send/receive commands into polled register accesses: status at addr 0, data at addr 1.
//  Sits between a byte-stream client (loader, debug monitor) and the UART; one command in flight at a time.
// PARAMETERS
//  ACK_TIMEOUT  16  cycles to wait for bus_rdy per access before aborting the command with rsp_err=1
//  POLL_GAP     4   idle cycles between consecutive status reads while polling
//  POLL_LIMIT   0   max status reads per command; 0 = unlimited; exceeded -> rsp_err=1
// PORTS
//  clk          in   1   clock
//  rst          in   1   synchronous reset, active low
//  cmd_valid    in   1   command request
//  cmd_ready    out  1   high in IDLE only; command accepted when cmd_valid & cmd_ready
//  cmd_op       in   1   0 = send byte, 1 = receive byte
//  cmd_data     in   8   byte to send (ignored for receive)
//  rsp_valid    out  1   one-cycle completion pulse
//  rsp_data     out  8   received byte (receive), 8'h00 for send or error
//  rsp_err      out  1   valid with rsp_valid: access timeout or poll limit exceeded
//  bus_cs       out  1   chip select, active high
//  bus_as       out  1   address strobe, active high
//  bus_rw       out  1   1 = write, 0 = read
//  bus_addr     out  1   0 = status/irq register, 1 = data register
//  bus_wr_data  out  32  write data
//  bus_rd_data  in   32  read data, sampled in cycle bus_rdy=1
//  bus_rdy      in   1   access acknowledge
// BEHAVIOUR
//  Reset (rst=0 at clk edge): state IDLE, cmd_ready=1, rsp_valid=0, rsp_data=0, rsp_err=0,
//   bus_cs=bus_as=bus_rw=bus_addr=0, bus_wr_data=0, timeout/gap/poll counters=0. Mid-command reset
//   abandons the access immediately; no rsp_valid is produced.
//  Status word: bit3 tx_busy, bit2 rx_busy, bit1 irq_tx, bit0 irq_rx (rx byte available).
//  Access rule: cs/as/rw/addr/wr_data driven from a register, held constant until the cycle bus_rdy=1;
//   in that cycle rd_data is captured and cs/as drop on the next edge (cs=as=0 for >=1 cycle between
//   accesses). Timeout counter clears at access start; reaching ACK_TIMEOUT without rdy -> drop cs/as,
//   go to DONE with rsp_err=1. bus_wr_data=0 on every read.
//  States: IDLE -> POLL (status read) -> GAP -> POLL ... -> XFER -> [CLR] -> DONE -> IDLE.
//  IDLE: cmd_ready=1; on accept latch cmd_op/cmd_data, clear poll count, enter POLL next cycle.
//  POLL: read addr 0. Send: tx_busy=0 -> XFER, else GAP. Receive: irq_rx=1 -> XFER, else GAP.
//   Each status read increments the poll count; POLL_LIMIT!=0 and count==POLL_LIMIT with condition
//   still false -> DONE, rsp_err=1.
//  GAP: bus idle exactly POLL_GAP cycles, then POLL.
//  XFER send: write addr 1, wr_data={24'h0,cmd_data} -> DONE. XFER receive: read addr 1, capture
//   rd_data[7:0] -> CLR.
//  CLR: write addr 0, wr_data=32'h0 (clears irq_rx and irq_tx) -> DONE.
//  DONE: rsp_valid=1 for exactly one cycle with rsp_data/rsp_err; next cycle IDLE (cmd_ready=1).
//  Ready-to-ack best case: send = status read + data write; receive = status + data read + clear.
//  cmd_valid while busy is ignored (not queued); client must hold it until accepted.
//  rsp_data/rsp_err hold their value until the next DONE.
// TESTING
//  1 Send 8'hA5, status 0x0 first read -> one status read, write addr1 data 32'h000000A5, rsp_valid, err=0.
//  2 Send with tx_busy=1 for 3 reads -> 4 status reads each separated by POLL_GAP idle cycles, then write.
//  3 Receive, irq_rx=1, data reg 32'h0000003C -> read addr1, write addr0 32'h0, rsp_data=8'h3C, err=0.
//  4 Responder never asserts rdy -> cs/as drop after ACK_TIMEOUT=16 cycles, rsp_valid with err=1, data=0.
//  5 POLL_LIMIT=2, irq_rx stays 0 -> exactly 2 status reads, then rsp_err=1; no data access issued.
//  6 rst=0 during CLR write -> next cycle all bus outputs 0, cmd_ready=1, no rsp_valid pulse.

Source files
------------

// File: rtl/uart_bus_master.sv
// uart_bus_master: turns single-byte send/receive commands into polled UART register accesses
module uart_bus_master #(
  parameter int ACK_TIMEOUT = 16,
  parameter int POLL_GAP    = 4,
  parameter int POLL_LIMIT  = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_op,
  input  logic [7:0]  cmd_data,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  output logic        rsp_err,
  output logic        bus_cs,
  output logic        bus_as,
  output logic        bus_rw,
  output logic        bus_addr,
  output logic [31:0] bus_wr_data,
  input  logic [31:0] bus_rd_data,
  input  logic        bus_rdy
);
  typedef enum logic [2:0] {IDLE, POLL, GAP, XFER, CLR, DONE} state_t;
  state_t state, nstate;
  logic op;
  logic [7:0] data, rx_byte;
  logic [15:0] tcnt, gcnt, pcnt;
  logic ack, tmo, ready_ok, limit_hit, fail, access, unused_bits;
  assign unused_bits = ^bus_rd_data[31:8];
  assign ack = bus_cs && bus_rdy;
  assign tmo = bus_cs && !bus_rdy && int'(tcnt) + 1 >= ACK_TIMEOUT;
  assign ready_ok = op ? bus_rd_data[0] : !bus_rd_data[3];
  assign limit_hit = POLL_LIMIT != 0 && int'(pcnt) + 1 == POLL_LIMIT;
  assign fail = tmo || (state == POLL && ack && !ready_ok && limit_hit);
  // an access starts only from an idle bus, so back-to-back accesses always get a cs-low cycle
  assign access = nstate inside {POLL, XFER, CLR};

  always_ff @(posedge clk)
    state <= !rst ? IDLE : nstate;

  always_comb begin
    nstate = state;
    case (state)
      IDLE: nstate = cmd_valid ? POLL : IDLE;
      POLL: nstate = tmo ? DONE : !ack ? POLL : ready_ok ? XFER : limit_hit ? DONE : GAP;
      GAP:  nstate = int'(gcnt) + 1 >= POLL_GAP ? POLL : GAP;
      XFER: nstate = tmo || (ack && !op) ? DONE : ack ? CLR : XFER;
      CLR:  nstate = tmo || ack ? DONE : CLR;
      DONE: nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = state == IDLE;
    rsp_valid = state == DONE;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      {op, data, rx_byte, tcnt, gcnt, pcnt} <= '0;
      {bus_cs, bus_as, bus_rw, bus_addr, bus_wr_data} <= '0;
      {rsp_data, rsp_err} <= '0;
    end else begin
      if (state == IDLE && cmd_valid) begin
        op <= cmd_op;
        data <= cmd_data;
        pcnt <= '0;
        rx_byte <= '0;
      end
      if (bus_cs) begin
        tcnt <= tcnt + 1'b1;
        if (ack || tmo) {bus_cs, bus_as, bus_rw, bus_addr, bus_wr_data} <= '0;
      end else if (access) begin
        tcnt <= '0;
        bus_cs <= 1'b1;
        bus_as <= 1'b1;
        bus_rw <= nstate == CLR || (nstate == XFER && !op);
        bus_addr <= nstate == XFER;
        bus_wr_data <= nstate == XFER && !op ? {24'h0, data} : 32'h0;
      end
      if (state == POLL && ack) pcnt <= pcnt + 1'b1;
      if (state == XFER && ack) rx_byte <= bus_rd_data[7:0];
      gcnt <= state == GAP ? gcnt + 1'b1 : '0;
      if (nstate == DONE && state != DONE) begin
        rsp_err <= fail;
        rsp_data <= fail || state != CLR ? 8'h0 : rx_byte;
      end
    end
  end
endmodule
